// File: rtl/spi_pkg.sv
// spi_pkg: SPI command-frame layout, slave FSM states and frame-size helpers.
package spi_pkg;

  // Default frame geometry for the 8-bit build.
  localparam int SPI_DW   = 8;
  localparam int CMD_BITS = 2 * SPI_DW + 1;

  // Field offsets within a command frame, bit 0 first on the wire.
  localparam int RW_BIT   = 0;
  localparam int ADDR_LSB = 1;
  localparam int DATA_LSB = ADDR_LSB + SPI_DW;

  typedef enum logic [2:0] {
    IDLE,
    CMD_SHIFT,
    DECODE,
    RESP_REQ,
    RESP_WAIT,
    RESP_SHIFT
  } spi_state_e;

  function automatic int cmd_bits(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int data_lsb(input int dw);
    return ADDR_LSB + dw;
  endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// spi_slave_regfile_if: SPI wires plus write-event and read-request sideband.
interface spi_slave_regfile_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  s_read_vld;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_err;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, s_read_vld, wr_vld, wr_addr, wr_data, frame_err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, s_read_vld, wr_vld, wr_addr, wr_data, frame_err
  );

endinterface

// File: rtl/spi_slv_edge_det.sv
// spi_slv_edge_det: SPI input conditioning and sclk/cs_n edge detection.
// Define SPI_SLV_SYNC_EN for a 2-flop synchronizer on every input.
module spi_slv_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_n,
  output logic o_cs_rise,
  output logic o_cs_fall,
  output logic o_mosi
);

  // Bit order {sclk, cs_n, mosi}. cs_n is held low through reset so that a frame
  // already running at release never shows a fall; only a fresh cs_n fall opens a frame.
  logic [2:0] r_sync;
  logic       r_sclk_d;
  logic       r_cs_d;

`ifdef SPI_SLV_SYNC_EN
  logic [2:0] r_meta;

  // Two-stage synchronizer for a slave clocked asynchronously to the master.
  always_ff @(posedge clk) begin
    r_meta <= rst ? 3'b000 : {i_sclk, i_cs_n, i_mosi};
    r_sync <= rst ? 3'b000 : r_meta;
  end
`else
  // Single input register; master and slave share this clock.
  always_ff @(posedge clk) r_sync <= rst ? 3'b000 : {i_sclk, i_cs_n, i_mosi};
`endif

  // Delayed copies of the conditioned sclk and cs_n feed the edge detectors.
  always_ff @(posedge clk) begin
    r_sclk_d <= rst ? 1'b0 : r_sync[2];
    r_cs_d   <= rst ? 1'b0 : r_sync[1];
  end

  assign o_sclk_rise = r_sync[2] & ~r_sclk_d;
  assign o_sclk_fall = ~r_sync[2] & r_sclk_d;
  assign o_cs_n      = r_sync[1];
  assign o_cs_rise   = r_sync[1] & ~r_cs_d;
  assign o_cs_fall   = ~r_sync[1] & r_cs_d;
  assign o_mosi      = r_sync[0];

endmodule

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI slave that decodes command frames into register writes and reads.
// Optional build macro SPI_SLV_SYNC_EN (see spi_slv_edge_det) adds input synchronizers.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic                clk,
  input logic                rst,
  spi_slave_regfile_if.slave bus
);

  localparam int NBITS = cmd_bits(DATA_WIDTH);
  localparam int DL    = data_lsb(DATA_WIDTH);
  localparam int CW    = $clog2(NBITS + 1);
  localparam int IW    = $clog2(DATA_WIDTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_n;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;

  spi_slv_edge_det u_edge (
    .clk         (clk),
    .rst         (rst),
    .i_sclk      (bus.sclk),
    .i_cs_n      (bus.cs_n),
    .i_mosi      (bus.mosi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_cs_n      (w_cs_n),
    .o_cs_rise   (w_cs_rise),
    .o_cs_fall   (w_cs_fall),
    .o_mosi      (w_mosi)
  );

  spi_state_e            r_state;
  logic [NBITS-1:0]      r_cmd;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  r_miso;
  logic                  r_s_read_vld;
  logic                  r_wr_vld;
  logic [DATA_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_frame_err;

  logic                  w_rw;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_in_range;
  logic [AW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_we;
  logic                  w_full;
  logic                  w_last;

  assign w_rw       = r_cmd[RW_BIT];
  assign w_addr     = r_cmd[ADDR_LSB +: DATA_WIDTH];
  assign w_wdata    = r_cmd[DL +: DATA_WIDTH];
  assign w_in_range = int'(w_addr) < DEPTH;
  assign w_idx      = w_addr[AW-1:0];
  assign w_rdata    = w_in_range ? r_regs[w_idx] : '0;
  assign w_we       = (r_state == DECODE) && !w_rw && w_in_range;
  assign w_full     = r_cnt == CW'(NBITS);
  assign w_last     = r_idx == IW'(DATA_WIDTH - 1);

  // Register file: cleared by reset, written only by an in-range decoded write.
  always_ff @(posedge clk) begin
    if (rst) r_regs <= '{default: '0};
    else if (w_we) r_regs[w_idx] <= w_wdata;
  end

  // Frame FSM with registered pulse outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cmd        <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_idx        <= '0;
      r_miso       <= 1'b0;
      r_s_read_vld <= 1'b0;
      r_wr_vld     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_s_read_vld <= 1'b0;
      r_wr_vld     <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= CMD_SHIFT;
            r_cnt   <= '0;
          end
        end
        CMD_SHIFT: begin
          if (w_cs_rise) begin
            r_state     <= w_full ? DECODE : IDLE;
            r_frame_err <= !w_full;
          end else if (w_sclk_rise && !w_full) begin
            r_cmd <= {w_mosi, r_cmd[NBITS-1:1]};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DECODE: begin
          r_state      <= w_rw ? RESP_REQ : IDLE;
          r_wr_vld     <= w_we;
          r_s_read_vld <= w_rw;
          r_rdata      <= w_rdata;
          r_miso       <= w_rw & w_rdata[0];
          if (w_we) begin
            r_wr_addr <= w_addr;
            r_wr_data <= w_wdata;
          end
        end
        RESP_REQ: r_state <= RESP_WAIT;
        RESP_WAIT: begin
          if (!w_cs_n) begin
            r_state <= RESP_SHIFT;
            r_idx   <= '0;
          end
        end
        RESP_SHIFT: begin
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
          end else if (w_sclk_fall) begin
            r_idx   <= r_idx + 1'b1;
            r_rdata <= r_rdata >> 1;
            r_miso  <= w_last ? 1'b0 : r_rdata[1];
            r_state <= w_last ? IDLE : RESP_SHIFT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.miso       = r_miso;
  assign bus.s_read_vld = r_s_read_vld;
  assign bus.wr_vld     = r_wr_vld;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_err  = r_frame_err;

endmodule
